// File: rtl/ifft8_pkg.sv
// Shared types and constants for the 8-point inverse transform.
// Holds the FSM state enum, Q1.14 twiddle tables and bitrev3().
package ifft8_pkg;

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

    localparam int TW_W = 16;

    // e^{+i*2*pi*j/8} for j = 0..3, scaled by 2^14
    localparam logic signed [TW_W-1:0] TW_COS [4] =
        '{16'sd16384, 16'sd11585, 16'sd0, -16'sd11585};
    localparam logic signed [TW_W-1:0] TW_SIN [4] =
        '{16'sd0, 16'sd11585, 16'sd16384, 16'sd11585};

    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

endpackage

// File: rtl/ifft8_stream_if.sv
// Bin input and sample output streams of ifft8_stream.
// slave: the transform block; master: its source/sink.
interface ifft8_stream_if #(parameter int DATA_W = 32);

    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_re;
    logic signed [DATA_W-1:0] s_im;
    logic                     m_valid;
    logic                     m_ready;
    logic signed [DATA_W-1:0] m_re;
    logic signed [DATA_W-1:0] m_im;
    logic                     m_last;

    modport slave (
        input  s_valid, s_re, s_im, m_ready,
        output s_ready, m_valid, m_re, m_im, m_last
    );

    modport master (
        output s_valid, s_re, s_im, m_ready,
        input  s_ready, m_valid, m_re, m_im, m_last
    );

endinterface

// File: rtl/cplx_bfly.sv
// Combinational radix-2 butterfly: t = xq*w, yp = xp+t, yq = xp-t.
// Ports: xp/xq operands, w twiddle (Q.TW_FRAC), yp/yq results.
module cplx_bfly
    import ifft8_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TW_FRAC = 14
) (
    input  logic signed [DATA_W-1:0] xp_re,
    input  logic signed [DATA_W-1:0] xp_im,
    input  logic signed [DATA_W-1:0] xq_re,
    input  logic signed [DATA_W-1:0] xq_im,
    input  logic signed [TW_W-1:0]   w_re,
    input  logic signed [TW_W-1:0]   w_im,
    output logic signed [DATA_W-1:0] yp_re,
    output logic signed [DATA_W-1:0] yp_im,
    output logic signed [DATA_W-1:0] yq_re,
    output logic signed [DATA_W-1:0] yq_im
);

    localparam int PW = DATA_W + TW_W;

    logic signed [PW-1:0]     ac, bs, as_p, bc;
    logic signed [DATA_W-1:0] t_re, t_im;

    assign ac   = PW'(xq_re) * PW'(w_re);
    assign bs   = PW'(xq_im) * PW'(w_im);
    assign as_p = PW'(xq_re) * PW'(w_im);
    assign bc   = PW'(xq_im) * PW'(w_re);

    // One guard bit for the sum, floor shift, then wrap to DATA_W
    assign t_re = DATA_W'(((PW+1)'(ac) - (PW+1)'(bs)) >>> TW_FRAC);
    assign t_im = DATA_W'(((PW+1)'(as_p) + (PW+1)'(bc)) >>> TW_FRAC);

    assign yp_re = xp_re + t_re;
    assign yp_im = xp_im + t_im;
    assign yq_re = xp_re - t_re;
    assign yq_im = xp_im - t_im;

endmodule

// File: rtl/ifft8_stream.sv
// Streaming 8-point inverse DFT, in-place radix-2 DIT, output scaled 1/8.
// Ports: clk, rst_n, io (bin in / sample out streams), busy.
module ifft8_stream
    import ifft8_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TW_FRAC = 14
) (
    input  logic           clk,
    input  logic           rst_n,
    ifft8_stream_if.slave  io,
    output logic           busy
);

    state_t      state;
    logic [2:0]  in_cnt;
    logic [2:0]  out_cnt;
    logic [3:0]  bf_cnt;
    logic        s_ready_q;
    logic        m_valid_q;

    logic signed [DATA_W-1:0] st_re [8];
    logic signed [DATA_W-1:0] st_im [8];

    logic [1:0] stage, idx, j;
    logic [2:0] p, q;

    logic signed [DATA_W-1:0] yp_re, yp_im, yq_re, yq_im;
    logic signed [DATA_W-1:0] out_re, out_im;

    assign stage = bf_cnt[3:2];
    assign idx   = bf_cnt[1:0];

    // Butterfly idx of a stage -> pair (p, q) and twiddle index j
    always_comb begin
        p = '0;
        q = '0;
        j = '0;
        unique case (stage)
            2'd0: begin
                p = {idx, 1'b0};
                q = {idx, 1'b1};
                j = 2'd0;
            end
            2'd1: begin
                p = {idx[1], 1'b0, idx[0]};
                q = {idx[1], 1'b1, idx[0]};
                j = {idx[0], 1'b0};
            end
            2'd2: begin
                p = {1'b0, idx};
                q = {1'b1, idx};
                j = idx;
            end
            default: ;
        endcase
    end

    cplx_bfly #(
        .DATA_W  (DATA_W),
        .TW_FRAC (TW_FRAC)
    ) u_bfly (
        .xp_re (st_re[p]),
        .xp_im (st_im[p]),
        .xq_re (st_re[q]),
        .xq_im (st_im[q]),
        .w_re  (TW_COS[j]),
        .w_im  (TW_SIN[j]),
        .yp_re (yp_re),
        .yp_im (yp_im),
        .yq_re (yq_re),
        .yq_im (yq_im)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            in_cnt    <= '0;
            out_cnt   <= '0;
            bf_cnt    <= '0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                st_re[i] <= '0;
                st_im[i] <= '0;
            end
        end else begin
            unique case (state)
                LOAD: begin
                    if (io.s_valid && s_ready_q) begin
                        st_re[bitrev3(in_cnt)] <= io.s_re;
                        st_im[bitrev3(in_cnt)] <= io.s_im;
                        in_cnt <= in_cnt + 3'd1;
                        if (in_cnt == 3'd7) begin
                            state     <= COMPUTE;
                            s_ready_q <= 1'b0;
                            bf_cnt    <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    st_re[p] <= yp_re;
                    st_im[p] <= yp_im;
                    st_re[q] <= yq_re;
                    st_im[q] <= yq_im;
                    bf_cnt   <= bf_cnt + 4'd1;
                    if (bf_cnt == 4'd11) begin
                        state     <= UNLOAD;
                        m_valid_q <= 1'b1;
                        out_cnt   <= '0;
                        bf_cnt    <= '0;
                    end
                end
                UNLOAD: begin
                    if (io.m_ready) begin
                        out_cnt <= out_cnt + 3'd1;
                        if (out_cnt == 3'd7) begin
                            state     <= LOAD;
                            m_valid_q <= 1'b0;
                            s_ready_q <= 1'b1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Store is frozen during UNLOAD, so the read is stable under stall
    assign out_re = st_re[out_cnt] >>> 3;
    assign out_im = st_im[out_cnt] >>> 3;

    assign io.s_ready = s_ready_q;
    assign io.m_valid = m_valid_q;
    assign io.m_re    = m_valid_q ? out_re : '0;
    assign io.m_im    = m_valid_q ? out_im : '0;
    assign io.m_last  = m_valid_q && (out_cnt == 3'd7);
    assign busy       = (state != LOAD);

endmodule

// File: tb/tb_ifft8_stream.sv
// Randomised self-checking bench for ifft8_stream against an IDFT model.
// Drives/samples on the falling edge; inputs take effect at the next rise.
module tb_ifft8_stream;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    always #5 clk = ~clk;

    ifft8_stream_if #(.DATA_W(W)) io ();

    ifft8_stream #(
        .DATA_W  (W),
        .TW_FRAC (14)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io),
        .busy  (busy)
    );

    int checks   = 0;
    int failures = 0;

    int bin_re [8];
    int bin_im [8];
    int exp_re [8];
    int exp_im [8];

    task automatic check(input string tag,
                         input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Textbook iterative DIT inverse DFT with Q14 twiddles from cos/sin
    function automatic void model();
        int     xr [8];
        int     xi [8];
        int     q, jj, tr, ti, pr, pi_;
        int     rv;
        longint a, b, c, s;
        real    ang;
        for (int k = 0; k < 8; k++) begin
            rv = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
            xr[rv] = bin_re[k];
            xi[rv] = bin_im[k];
        end
        for (int span = 1; span < 8; span = span * 2) begin
            for (int pp = 0; pp < 8; pp++) begin
                if ((pp & span) == 0) begin
                    q   = pp + span;
                    jj  = (pp % span) * (4 / span);
                    ang = 2.0 * 3.14159265358979 * jj / 8.0;
                    c   = longint'($cos(ang) * 16384.0);
                    s   = longint'($sin(ang) * 16384.0);
                    a   = longint'(xr[q]);
                    b   = longint'(xi[q]);
                    tr  = int'((a * c - b * s) >>> 14);
                    ti  = int'((a * s + b * c) >>> 14);
                    pr  = xr[pp];
                    pi_ = xi[pp];
                    xr[pp] = pr + tr;
                    xi[pp] = pi_ + ti;
                    xr[q]  = pr - tr;
                    xi[q]  = pi_ - ti;
                end
            end
        end
        for (int n = 0; n < 8; n++) begin
            exp_re[n] = xr[n] >>> 3;
            exp_im[n] = xi[n] >>> 3;
        end
    endfunction

    // Returns at the falling edge one cycle after the 8th acceptance
    task automatic send(input bit gaps, input bit hold_after);
        int k = 0;
        int guard = 0;
        while (k < 8 && guard < 500) begin
            @(negedge clk);
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                io.s_valid = 1'b0;
            end else begin
                io.s_valid = 1'b1;
                io.s_re    = bin_re[k];
                io.s_im    = bin_im[k];
                if (io.s_ready) k++;
            end
        end
        if (k < 8) check("send_timeout", k, 8);
        @(negedge clk);
        io.s_valid = hold_after;
        io.s_re    = $urandom;
        io.s_im    = $urandom;
    endtask

    task automatic recv(input int mode, output int lat);
        int  n = 0;
        int  i = 0;
        bit  rdy;
        bit  stalled = 0;
        bit  bad_wait = 0;
        logic signed [W-1:0] prev_re, prev_im;
        logic prev_last;
        lat = 1;
        io.m_ready = 1'b0;
        while (!io.m_valid && lat < 100) begin
            if (io.s_ready || !busy) bad_wait = 1;
            @(negedge clk);
            lat++;
        end
        check("wait_sready_busy", bad_wait, 0);
        while (n < 8 && i < 300) begin
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = (i % 3 == 0);
            else                rdy = 1'($urandom_range(0, 1));
            io.m_ready = rdy;
            if (stalled) begin
                check("stall_valid", io.m_valid, 1);
                check("stall_re", io.m_re, prev_re);
                check("stall_im", io.m_im, prev_im);
                check("stall_last", io.m_last, prev_last);
            end
            if (io.m_valid && rdy) begin
                check($sformatf("beat%0d_re", n), io.m_re, exp_re[n]);
                check($sformatf("beat%0d_im", n), io.m_im, exp_im[n]);
                check($sformatf("beat%0d_last", n), io.m_last, n == 7);
                check($sformatf("beat%0d_sready", n), io.s_ready, 0);
                n++;
                if (n == 8) io.s_valid = 1'b0;
                stalled = 0;
            end else begin
                stalled   = io.m_valid;
                prev_re   = io.m_re;
                prev_im   = io.m_im;
                prev_last = io.m_last;
            end
            @(negedge clk);
            i++;
        end
        if (n < 8) check("recv_timeout", n, 8);
        io.m_ready = 1'b0;
        check("end_mvalid", io.m_valid, 0);
        check("end_sready", io.s_ready, 1);
        check("end_mlast", io.m_last, 0);
        check("end_busy", busy, 0);
    endtask

    task automatic run_frame(input bit gaps, input bit hold, input int mode);
        int lat;
        send(gaps, hold);
        recv(mode, lat);
        check("latency", lat, 13);
    endtask

    task automatic set_impulse();
        for (int k = 0; k < 8; k++) begin
            bin_re[k] = 0;
            bin_im[k] = 0;
            exp_re[k] = 1;
            exp_im[k] = 0;
        end
        bin_re[0] = 8;
    endtask

    task automatic set_tone();
        int er [8] = '{8192, 5792, 0, -5793, -8192, -5793, 0, 5792};
        int ei [8] = '{0, 5792, 8192, 5792, 0, -5793, -8192, -5793};
        for (int k = 0; k < 8; k++) begin
            bin_re[k] = 0;
            bin_im[k] = 0;
            exp_re[k] = er[k];
            exp_im[k] = ei[k];
        end
        bin_re[1] = 65536;
    endtask

    initial begin
        bit stray;
        rst_n      = 1'b0;
        io.s_valid = 1'b0;
        io.s_re    = '0;
        io.s_im    = '0;
        io.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sready", io.s_ready, 1);
        check("rst_mvalid", io.m_valid, 0);
        check("rst_mlast", io.m_last, 0);
        check("rst_mre", io.m_re, 0);
        check("rst_mim", io.m_im, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        // impulse
        set_impulse();
        run_frame(0, 0, 0);

        // constant
        for (int k = 0; k < 8; k++) begin
            bin_re[k] = 8;
            bin_im[k] = 0;
            exp_re[k] = 0;
            exp_im[k] = 0;
        end
        exp_re[0] = 8;
        run_frame(0, 0, 0);

        // single tone, then same tone under 1,0,0 backpressure
        set_tone();
        run_frame(0, 0, 0);
        run_frame(0, 0, 1);

        // reset in the 5th COMPUTE cycle
        set_tone();
        send(0, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_mvalid", io.m_valid, 0);
        check("midrst_sready", io.s_ready, 1);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (io.m_valid || !io.s_ready) stray = 1;
        end
        check("midrst_quiet", stray, 0);
        set_impulse();
        run_frame(0, 0, 0);

        // input gaps plus s_valid held through COMPUTE/UNLOAD
        set_tone();
        run_frame(1, 1, 0);

        // random bins against the model
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 8; k++) begin
                if (f < 4) begin
                    bin_re[k] = $urandom_range(0, 2000000) - 1000000;
                    bin_im[k] = $urandom_range(0, 2000000) - 1000000;
                end else begin
                    bin_re[k] = $urandom;
                    bin_im[k] = $urandom;
                end
            end
            model();
            run_frame(1, f[0], 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
